data_cache: RTL and testbench

- Memory (MEM) pipeline stage of the 5-stage RV32I core, placed between the execute stage and write-back.
- Registers the instruction leaving execute and services its LOAD/STORE through a direct-mapped, write-back, write-allocate data cache.
- On a miss it drives the DRAM handshake and asserts freeze_cpu until the access completes.
- Passes ALU results of non-memory instructions to write-back.

---
 rtl/core_pkg.sv | 39 +++
 rtl/data_cache_lane.sv | 53 +++++
 rtl/data_cache.sv | 189 ++++++++++++++++++
 tb/tb_data_cache.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, funct3 encodings, DRAM commands
// and the data cache controller states.
package core_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ADDI x0,x0,0 used as the pipeline bubble
  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    DRAM_IDLE  = 2'd0,
    DRAM_READ  = 2'd1,
    DRAM_WRITE = 2'd2
  } dram_cmd_e;

  typedef enum logic [1:0] {
    CACHE_IDLE = 2'd0,
    CACHE_WB   = 2'd1,
    CACHE_FILL = 2'd2
  } cache_state_e;

endpackage

// File: rtl/data_cache_lane.sv
// Byte/halfword lane logic for the data cache: load extraction with sign or
// zero extension, and byte-merge of store data into a cached word.
module data_cache_lane
  import core_pkg::*;
(
  input  logic [31:0] line,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_line
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it to a full register value
  always_comb begin
    byte_s = line[{offset, 3'b000} +: 8];
    if (offset[1]) begin
      half_s = line[31:16];
    end else begin
      half_s = line[15:0];
    end
    case (funct3)
      F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      F3_LH:   load_data = {{16{half_s[15]}}, half_s};
      F3_LW:   load_data = line;
      F3_LBU:  load_data = {24'h000000, byte_s};
      F3_LHU:  load_data = {16'h0000, half_s};
      default: load_data = line;
    endcase
  end

  // Merge the store lanes into the current line; offset bits below the
  // access size are ignored
  always_comb begin
    store_line = line;
    case (funct3)
      F3_SB: store_line[{offset, 3'b000} +: 8] = store_data[7:0];
      F3_SH: begin
        if (offset[1]) begin
          store_line[31:16] = store_data[15:0];
        end else begin
          store_line[15:0] = store_data[15:0];
        end
      end
      F3_SW:   store_line = store_data;
      default: store_line = line;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// MEM stage of the RV32I pipeline with a direct-mapped, write-back,
// write-allocate data cache (one word per line). A miss freezes the core
// while the victim is written back (if dirty) and the line is filled.
// Optional macro DATA_CACHE_STATS_EN adds hit_count / miss_count outputs.
module data_cache #(
  parameter int unsigned NUM_LINES = 16,
  parameter logic [31:0] NOP_INST  = core_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exe_inst,
  input  logic [31:0] exe_result,
  input  logic [31:0] exe_store_data,
  output logic [31:0] mem_inst,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_result,
  output logic [31:0] write_back_inst,
  output logic        freeze_cpu,
  output logic [1:0]  dram_signal,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_write_data,
  input  logic        dram_ready,
  input  logic [31:0] dram_result
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  import core_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [31:0]          mem_inst_r, mem_addr_r, store_data_r;
  logic [31:0]          wb_inst_r, mem_result_r;
  cache_state_e         state_r;
  logic [NUM_LINES-1:0] valid_r, dirty_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [31:0]          data_r [NUM_LINES];

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic [31:0]      line_s, load_data_s, store_line_s;
  logic             is_load_s, is_store_s, hit_s, freeze_s;
  dram_cmd_e        dram_cmd_s;
  logic [31:0]      dram_addr_s, dram_wdata_s;

  assign idx_s  = mem_addr_r[2 +: IDX_W];
  assign tag_s  = mem_addr_r[31 -: TAG_W];
  assign line_s = data_r[idx_s];

  data_cache_lane u_lane (
    .line       (line_s),
    .offset     (mem_addr_r[1:0]),
    .funct3     (mem_inst_r[14:12]),
    .store_data (store_data_r),
    .load_data  (load_data_s),
    .store_line (store_line_s)
  );

  // Hit detection; non-memory instructions always hit
  always_comb begin
    is_load_s  = (mem_inst_r[6:0] == OPC_LOAD);
    is_store_s = (mem_inst_r[6:0] == OPC_STORE);
    if (is_load_s || is_store_s) begin
      hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    end else begin
      hit_s = 1'b1;
    end
    freeze_s = (state_r != CACHE_IDLE) || !hit_s;
  end

  // DRAM command decode; everything here comes from registers, so it is
  // stable for the whole transaction
  always_comb begin
    dram_cmd_s   = DRAM_IDLE;
    dram_addr_s  = 32'h00000000;
    dram_wdata_s = 32'h00000000;
    case (state_r)
      CACHE_WB: begin
        dram_cmd_s   = DRAM_WRITE;
        dram_addr_s  = {tag_r[idx_s], idx_s, 2'b00};
        dram_wdata_s = line_s;
      end
      CACHE_FILL: begin
        dram_cmd_s  = DRAM_READ;
        dram_addr_s = {tag_s, idx_s, 2'b00};
      end
      default: begin
        dram_cmd_s = DRAM_IDLE;
      end
    endcase
  end

  // Pipeline registers: advance when not frozen, feed bubbles to WB while frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_inst_r   <= NOP_INST;
      mem_addr_r   <= 32'h00000000;
      store_data_r <= 32'h00000000;
      wb_inst_r    <= NOP_INST;
      mem_result_r <= 32'h00000000;
    end else if (freeze_s) begin
      wb_inst_r    <= NOP_INST;
      mem_result_r <= 32'h00000000;
    end else begin
      mem_inst_r   <= exe_inst;
      mem_addr_r   <= exe_result;
      store_data_r <= exe_store_data;
      wb_inst_r    <= mem_inst_r;
      mem_result_r <= is_load_s ? load_data_s : mem_addr_r;
    end
  end

  // Miss controller and cache arrays; store hits merge into the line on retire
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CACHE_IDLE;
      valid_r <= '0;
      dirty_r <= '0;
    end else begin
      case (state_r)
        CACHE_IDLE: begin
          if (!hit_s) begin
            if (valid_r[idx_s] && dirty_r[idx_s]) begin
              state_r <= CACHE_WB;
            end else begin
              state_r <= CACHE_FILL;
            end
          end else if (is_store_s) begin
            data_r[idx_s]  <= store_line_s;
            dirty_r[idx_s] <= 1'b1;
          end
        end
        CACHE_WB: begin
          if (dram_ready) begin
            dirty_r[idx_s] <= 1'b0;
            state_r        <= CACHE_FILL;
          end
        end
        CACHE_FILL: begin
          if (dram_ready) begin
            data_r[idx_s]  <= dram_result;
            tag_r[idx_s]   <= tag_s;
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
            state_r        <= CACHE_IDLE;
          end
        end
        default: state_r <= CACHE_IDLE;
      endcase
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic missed_r;

  // Access statistics: each retiring LOAD/STORE counted once, as a miss if it ever stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 32'h00000000;
      miss_count <= 32'h00000000;
      missed_r   <= 1'b0;
    end else if (freeze_s) begin
      missed_r <= 1'b1;
    end else begin
      missed_r <= 1'b0;
      if (is_load_s || is_store_s) begin
        if (missed_r) begin
          miss_count <= miss_count + 32'd1;
        end else begin
          hit_count <= hit_count + 32'd1;
        end
      end
    end
  end
`endif

  assign mem_inst        = mem_inst_r;
  assign mem_addr        = mem_addr_r;
  assign mem_result      = mem_result_r;
  assign write_back_inst = wb_inst_r;
  assign freeze_cpu      = freeze_s;
  assign dram_signal     = dram_cmd_s;
  assign dram_addr       = dram_addr_s;
  assign dram_write_data = dram_wdata_s;

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache with a fixed-latency DRAM responder.
module tb_data_cache;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] exe_inst = NOP, exe_result = 32'h0, exe_store_data = 32'h0;
  logic [31:0] mem_inst, mem_addr, mem_result, write_back_inst;
  logic        freeze_cpu;
  logic [1:0]  dram_signal;
  logic [31:0] dram_addr, dram_write_data;
  logic        dram_ready = 1'b0;
  logic [31:0] dram_result = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] dmem [0:255];
  int cnt = 0, n_reads = 0, n_writes = 0, op_seq = 0, wr_seq = 0, rd_seq = 0;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0, last_rd_addr = 32'h0;

  data_cache #(.NUM_LINES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .exe_inst        (exe_inst),
    .exe_result      (exe_result),
    .exe_store_data  (exe_store_data),
    .mem_inst        (mem_inst),
    .mem_addr        (mem_addr),
    .mem_result      (mem_result),
    .write_back_inst (write_back_inst),
    .freeze_cpu      (freeze_cpu),
    .dram_signal     (dram_signal),
    .dram_addr       (dram_addr),
    .dram_write_data (dram_write_data),
    .dram_ready      (dram_ready),
    .dram_result     (dram_result)
  );

  always #5 clk = ~clk;

  // DRAM model: answers a held command after LAT cycles with a one-cycle ready pulse
  always @(negedge clk) begin
    dram_ready = 1'b0;
    if (rst || dram_signal == 2'd0) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt == LAT) begin
        cnt = 0;
        dram_ready = 1'b1;
        op_seq++;
        if (dram_signal == 2'd1) begin
          dram_result = dmem[dram_addr[9:2]];
          n_reads++;
          rd_seq = op_seq;
          last_rd_addr = dram_addr;
        end else begin
          dmem[dram_addr[9:2]] = dram_write_data;
          n_writes++;
          wr_seq = op_seq;
          last_wr_addr = dram_addr;
          last_wr_data = dram_write_data;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld(input logic [2:0] f3);
    return {12'h000, 5'd0, f3, 5'd5, 7'b0000011};
  endfunction

  function automatic logic [31:0] st(input logic [2:0] f3);
    return {7'h00, 5'd2, 5'd0, f3, 5'h00, 7'b0100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] sd);
    exe_inst = inst;
    exe_result = addr;
    exe_store_data = sd;
    tick();
    exe_inst = NOP;
    exe_result = 32'h0;
    exe_store_data = 32'h0;
  endtask

  task automatic wait_unfreeze(output int frozen);
    frozen = 0;
    while (freeze_cpu && frozen < 100) begin
      tick();
      frozen++;
    end
    check_eq("unfreeze", {31'h0, freeze_cpu}, 32'h0);
  endtask

  task automatic mem_op(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] exp, input int exp_frozen);
    int fr;
    issue(inst, addr, sd);
    wait_unfreeze(fr);
    check_eq({tag, "_stall"}, 32'(fr), 32'(exp_frozen));
    tick();
    check_eq({tag, "_wb"}, write_back_inst, inst);
    check_eq({tag, "_res"}, mem_result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int fr;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[8'd64] = 32'hDEADBEEF;   // 0x100
    dmem[8'd80] = 32'hCAFEF00D;   // 0x140

    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_mem_inst", mem_inst, NOP);
    check_eq("rst_wb_inst", write_back_inst, NOP);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_result", mem_result, 32'h0);
    check_eq("rst_freeze", {31'h0, freeze_cpu}, 32'h0);
    check_eq("rst_dram_sig", {30'h0, dram_signal}, 32'h0);

    // Cold load miss
    issue(ld(3'b010), 32'h100, 32'h0);
    check_eq("cold_freeze", {31'h0, freeze_cpu}, 32'h1);
    check_eq("cold_sig_idle", {30'h0, dram_signal}, 32'h0);
    tick();
    check_eq("cold_sig_read", {30'h0, dram_signal}, 32'h1);
    check_eq("cold_addr", dram_addr, 32'h100);
    check_eq("cold_bubble_wb", write_back_inst, NOP);
    check_eq("cold_bubble_res", mem_result, 32'h0);
    wait_unfreeze(fr);
    check_eq("cold_stall", 32'(fr), 32'd3);
    tick();
    check_eq("cold_wb", write_back_inst, ld(3'b010));
    check_eq("cold_res", mem_result, 32'hDEADBEEF);

    // Repeat hit: no further DRAM traffic
    mem_op("hit_lw", ld(3'b010), 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check_eq("hit_reads", 32'(n_reads), 32'd1);

    // Byte store and sub-word loads (line becomes 0xDEAD7FEF)
    mem_op("sb", st(3'b000), 32'h101, 32'h0000007F, 32'h101, 0);
    mem_op("lbu", ld(3'b100), 32'h101, 32'h0, 32'h0000007F, 0);
    mem_op("lb", ld(3'b000), 32'h103, 32'h0, 32'hFFFFFFDE, 0);
    mem_op("lh", ld(3'b001), 32'h102, 32'h0, 32'hFFFFDEAD, 0);
    mem_op("lhu", ld(3'b101), 32'h100, 32'h0, 32'h00007FEF, 0);
    mem_op("lw_mis", ld(3'b010), 32'h102, 32'h0, 32'hDEAD7FEF, 0);

    // Dirty conflict: write-back then fill
    mem_op("sw", st(3'b010), 32'h100, 32'h11111111, 32'h100, 0);
    mem_op("conf_lw", ld(3'b010), 32'h140, 32'h0, 32'hCAFEF00D, 2 * LAT + 1);
    check_eq("conf_writes", 32'(n_writes), 32'd1);
    check_eq("conf_wr_addr", last_wr_addr, 32'h100);
    check_eq("conf_wr_data", last_wr_data, 32'h11111111);
    check_eq("conf_rd_addr", last_rd_addr, 32'h140);
    check_eq("conf_order", {31'h0, wr_seq < rd_seq}, 32'h1);

    // Clean victim: fill only
    mem_op("clean_lw", ld(3'b010), 32'h100, 32'h0, 32'h11111111, LAT + 1);
    check_eq("clean_writes", 32'(n_writes), 32'd1);

    // ALU result pass-through
    mem_op("addi", {12'd42, 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'd42, 32'h0, 32'd42, 0);
    check_eq("addi_reads", 32'(n_reads), 32'd3);

    // Reset during FILL
    issue(ld(3'b010), 32'h140, 32'h0);
    check_eq("rf_freeze", {31'h0, freeze_cpu}, 32'h1);
    tick();
    check_eq("rf_sig_read", {30'h0, dram_signal}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rf_sig", {30'h0, dram_signal}, 32'h0);
    check_eq("rf_freeze0", {31'h0, freeze_cpu}, 32'h0);
    check_eq("rf_mem_inst", mem_inst, NOP);
    check_eq("rf_wb_inst", write_back_inst, NOP);
    mem_op("rf_relw", ld(3'b010), 32'h100, 32'h0, 32'h11111111, LAT + 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
